// File: rtl/ice51_mem_pkg.sv
// ----------------------------------------------------------------------------
// ice51_mem_pkg
// Shared definitions for the multi-channel memory controller.
//   DEF_WIDTH / DEF_DEPTH / DEF_NUM_CH : default parameter values
//   clog2Min1()  : ceil(log2(value)), never less than 1, for port widths
//   rrNext()     : next channel index in round-robin order
// No ports; imported by ice51_mem_sp and ice51_mem_ctrl.
// ----------------------------------------------------------------------------
package ice51_mem_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DEPTH  = 512;
   localparam int DEF_NUM_CH = 2;

   // Smallest r with 2**r >= value, clamped to 1 so a single-entry index
   // still gets a real one-bit signal.
   function automatic int clog2Min1(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Index that follows 'last' when walking channels 0..numCh-1 in a ring.
   function automatic int rrNext(input int last, input int numCh);
      return (last + 1 >= numCh) ? 0 : last + 1;
   endfunction

endpackage

// File: rtl/ice51_mem_sp.sv
// ----------------------------------------------------------------------------
// ice51_mem_sp
// Single-port synchronous RAM with a registered read port. The array itself
// is never reset; the read register only updates when a read is requested,
// so o_rdata holds the last word read.
// Ports:
//   i_clk    clock
//   i_we     write enable (i_addr must be in range)
//   i_re     read enable  (i_addr must be in range)
//   i_addr   word address
//   i_wdata  write word
//   o_rdata  word read on the previous enabled read
// ----------------------------------------------------------------------------
module ice51_mem_sp
   import ice51_mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = clog2Min1(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdData_q;

   // Storage and registered read share one port; the controller never asks
   // for both in the same cycle, and never with an out-of-range address.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         rdData_q <= mem[i_addr];
      end
   end

   assign o_rdata = rdData_q;

endmodule

// File: rtl/ice51_mem_ctrl.sv
// ----------------------------------------------------------------------------
// ice51_mem_ctrl
// Round-robin arbiter in front of one single-port RAM. Each cycle at most one
// requesting channel is granted and its access completes on that clock edge;
// read data comes back one cycle later on the shared o_rdata bus.
// Optional feature macro: ICE51_MEM_CTRL_PARITY_EN adds one even-parity bit
// per stored word and the o_par_err output.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_req      per-channel request, held until granted
//   i_we       per-channel write enable
//   i_addr     per-channel word address, channel n at [n*AW +: AW]
//   i_wdata    per-channel write data, channel n at [n*WIDTH +: WIDTH]
//   o_gnt      one-hot grant (combinational)
//   o_rvalid   one-hot read-data-valid pulse, one cycle after a read grant
//   o_rdata    shared read data, held while o_rvalid is 0
//   o_par_err  parity mismatch pulse alongside o_rvalid (macro only)
// ----------------------------------------------------------------------------
module ice51_mem_ctrl
   import ice51_mem_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_CH = DEF_NUM_CH,
   localparam int AW    = clog2Min1(DEPTH),
   localparam int CW    = clog2Min1(NUM_CH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_CH-1:0]       i_req,
   input  logic [NUM_CH-1:0]       i_we,
   input  logic [NUM_CH*AW-1:0]    i_addr,
   input  logic [NUM_CH*WIDTH-1:0] i_wdata,
   output logic [NUM_CH-1:0]       o_gnt,
   output logic [NUM_CH-1:0]       o_rvalid,
   output logic [WIDTH-1:0]        o_rdata
`ifdef ICE51_MEM_CTRL_PARITY_EN
   ,
   output logic                    o_par_err
`endif
);

`ifdef ICE51_MEM_CTRL_PARITY_EN
   localparam int RW = WIDTH + 1;
`else
   localparam int RW = WIDTH;
`endif

   logic [CW-1:0]     lastGnt_q;
   logic [CW-1:0]     gntIdx;
   logic              anyGnt;
   logic [NUM_CH-1:0] gnt;
   logic [AW-1:0]     selAddr;
   logic              selWe;
   logic [WIDTH-1:0]  selWdata;
   logic              inRange;
   logic              isRead;
   logic              ramWe;
   logic              ramRe;
   logic [RW-1:0]     ramWdata;
   logic [RW-1:0]     ramQ;
   logic [NUM_CH-1:0] rvalid_q;
   logic [NUM_CH-1:0] rvalid_d;
   logic              zeroRd_q;
   logic              zeroRd_d;

   // Round-robin search: walk the ring starting just after the last winner
   // and take the first requester. Nothing is granted while in reset.
   always_comb begin
      int idx;
      gnt    = '0;
      gntIdx = lastGnt_q;
      anyGnt = 1'b0;
      idx    = int'(lastGnt_q);
      for (int k = 0; k < NUM_CH; k++) begin
         idx = rrNext(idx, NUM_CH);
         if (!anyGnt && i_req[idx] && !i_rst) begin
            anyGnt = 1'b1;
            gntIdx = CW'(idx);
         end
      end
      if (anyGnt) begin
         gnt[gntIdx] = 1'b1;
      end
   end

   assign o_gnt = gnt;

   // The pointer only exists with more than one channel; a single channel
   // always wins, so its pointer is a constant.
   generate
      if (NUM_CH == 1) begin : gSingle
         assign lastGnt_q = '0;
      end else begin : gMulti
         logic [CW-1:0] lastGnt_d;
         assign lastGnt_d = anyGnt ? gntIdx : lastGnt_q;

         // Reset parks the pointer on the last channel so channel 0 wins first.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               lastGnt_q <= CW'(NUM_CH - 1);
            end else begin
               lastGnt_q <= lastGnt_d;
            end
         end
      end
   endgenerate

   // Route the winning channel's command to the RAM. Addresses at or past
   // DEPTH never reach the array: writes are dropped, reads return zero.
   always_comb begin
      selAddr  = i_addr[int'(gntIdx)*AW +: AW];
      selWe    = i_we[gntIdx];
      selWdata = i_wdata[int'(gntIdx)*WIDTH +: WIDTH];
      inRange  = int'(selAddr) < DEPTH;
      isRead   = anyGnt && !selWe;
      ramWe    = anyGnt && selWe && inRange;
      ramRe    = isRead && inRange;
      rvalid_d = isRead ? gnt : '0;
      zeroRd_d = isRead ? !inRange : zeroRd_q;
   end

`ifdef ICE51_MEM_CTRL_PARITY_EN
   assign ramWdata = {^selWdata, selWdata};
`else
   assign ramWdata = selWdata;
`endif

   ice51_mem_sp #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) uMem (
      .i_clk   (i_clk),
      .i_we    (ramWe),
      .i_re    (ramRe),
      .i_addr  (selAddr),
      .i_wdata (ramWdata),
      .o_rdata (ramQ)
   );

   // Read-valid pulse plus a sticky "last read returned zero" flag; the flag
   // lets o_rdata hold zero after an out-of-range read without disturbing the
   // RAM's own read register. Reset selects zero on the data bus.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rvalid_q <= '0;
         zeroRd_q <= 1'b1;
      end else begin
         rvalid_q <= rvalid_d;
         zeroRd_q <= zeroRd_d;
      end
   end

   // Outputs are forced low while reset is high, which also swallows a read
   // pulse that was granted in the cycle just before reset rose.
   assign o_rvalid = i_rst ? '0 : rvalid_q;
   assign o_rdata  = (i_rst || zeroRd_q) ? '0 : ramQ[WIDTH-1:0];

`ifdef ICE51_MEM_CTRL_PARITY_EN
   // Even parity over data plus stored bit must be zero on a good word.
   assign o_par_err = !i_rst && (|rvalid_q) && !zeroRd_q && (^ramQ);
`endif

endmodule

// File: tb/tb_ice51_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ice51_mem_ctrl
// Directed and random stimulus for ice51_mem_ctrl (4 channels, 300 words),
// compared each cycle with a behavioural model of the arbiter and memory.
// Parity checks are compiled in when ICE51_MEM_CTRL_PARITY_EN is defined.
// ----------------------------------------------------------------------------
module tb_ice51_mem_ctrl;
   import ice51_mem_pkg::*;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 300;
   localparam int NUM_CH = 4;
   localparam int AW     = clog2Min1(DEPTH);

   logic                    clk;
   logic                    rst;
   logic [NUM_CH-1:0]       req;
   logic [NUM_CH-1:0]       we;
   logic [NUM_CH*AW-1:0]    addr;
   logic [NUM_CH*WIDTH-1:0] wdata;
   logic [NUM_CH-1:0]       gnt;
   logic [NUM_CH-1:0]       rvalid;
   logic [WIDTH-1:0]        rdata;
`ifdef ICE51_MEM_CTRL_PARITY_EN
   logic                    parErr;
`endif

   ice51_mem_ctrl #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .NUM_CH (NUM_CH)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .i_we      (we),
      .i_addr    (addr),
      .i_wdata   (wdata),
      .o_gnt     (gnt),
      .o_rvalid  (rvalid),
      .o_rdata   (rdata)
`ifdef ICE51_MEM_CTRL_PARITY_EN
      ,
      .o_par_err (parErr)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int testCount = 0;
   int failCount = 0;

   // Stimulus for the coming cycle.
   logic              drvRst;
   logic [NUM_CH-1:0] drvReq;
   logic [NUM_CH-1:0] drvWe;
   int                drvAddr  [NUM_CH];
   int                drvWdata [NUM_CH];

   // Reference model: memory image, arbiter pointer, outputs expected now.
   int                modelMem [DEPTH];
   bit                corrupt  [DEPTH];
   int                lastGranted;
   logic [NUM_CH-1:0] expRvalid;
   int                expRdata;
   bit                expPar;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic idleAll();
      drvReq = '0;
      drvWe  = '0;
   endtask

   task automatic setCh(input int ch, input bit w, input int a, input int d);
      drvReq[ch]   = 1'b1;
      drvWe[ch]    = w;
      drvAddr[ch]  = a;
      drvWdata[ch] = d;
   endtask

   // Drive one cycle, compare outputs against the model, advance the model,
   // then step past the rising edge.
   task automatic applyStimulus();
      logic [NUM_CH-1:0] expGnt;
      int winner;
      rst = drvRst;
      req = drvReq;
      we  = drvWe;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         addr[ch*AW +: AW]       = AW'(drvAddr[ch]);
         wdata[ch*WIDTH +: WIDTH] = WIDTH'(drvWdata[ch]);
      end
      #1;
      if (drvRst) begin
         checkOutput("gnt_rst", 32'(gnt), 32'd0);
         checkOutput("rvalid_rst", 32'(rvalid), 32'd0);
         checkOutput("rdata_rst", 32'(rdata), 32'd0);
`ifdef ICE51_MEM_CTRL_PARITY_EN
         checkOutput("parerr_rst", 32'(parErr), 32'd0);
`endif
         lastGranted = NUM_CH - 1;
         expRvalid   = '0;
         expRdata    = 0;
         expPar      = 1'b0;
      end else begin
         checkOutput("rvalid", 32'(rvalid), 32'(expRvalid));
         checkOutput("rdata", 32'(rdata), 32'(expRdata));
`ifdef ICE51_MEM_CTRL_PARITY_EN
         checkOutput("parerr", 32'(parErr), 32'(expPar));
`endif
         winner = -1;
         for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (lastGranted + k) % NUM_CH;
            if (winner < 0 && drvReq[c]) winner = c;
         end
         expGnt = '0;
         if (winner >= 0) expGnt[winner] = 1'b1;
         checkOutput("gnt", 32'(gnt), 32'(expGnt));
         expRvalid = '0;
         expPar    = 1'b0;
         if (winner >= 0) begin
            lastGranted = winner;
            if (drvWe[winner]) begin
               if (drvAddr[winner] < DEPTH) begin
                  modelMem[drvAddr[winner]] = drvWdata[winner];
                  corrupt[drvAddr[winner]]  = 1'b0;
               end
            end else begin
               expRvalid = expGnt;
               if (drvAddr[winner] < DEPTH) begin
                  expRdata = modelMem[drvAddr[winner]];
                  expPar   = corrupt[drvAddr[winner]];
               end else begin
                  expRdata = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, failed=%0d", failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a random soak.
   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         drvAddr[i]  = 0;
         drvWdata[i] = 0;
      end
      for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
      lastGranted = NUM_CH - 1;
      expRvalid   = '0;
      expRdata    = 0;
      expPar      = 1'b0;

      // Reset with requests present; they must be ignored.
      idleAll();
      drvRst = 1'b1;
      setCh(0, 1'b1, 16, 8'h77);
      applyStimulus();
      applyStimulus();
      drvRst = 1'b0;

      // Fill the whole memory, rotating the writing channel.
      for (int i = 0; i < DEPTH; i++) begin
         idleAll();
         setCh(i % NUM_CH, 1'b1, i, $urandom_range(0, 255));
         applyStimulus();
      end

      // Reset, then ch0 writes 0xA5 @0x010 and ch1 reads it back.
      idleAll();
      drvRst = 1'b1;
      applyStimulus();
      drvRst = 1'b0;
      setCh(0, 1'b1, 16, 8'hA5);
      applyStimulus();
      idleAll();
      setCh(1, 1'b0, 16, 0);
      applyStimulus();
      idleAll();
      applyStimulus();
      applyStimulus();

      // RAM survives reset; all channels hammering gives 0001,0010,0100,1000...
      drvRst = 1'b1;
      applyStimulus();
      drvRst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         idleAll();
         for (int ch = 0; ch < NUM_CH; ch++) setCh(ch, 1'b0, 16 + ch, 0);
         applyStimulus();
      end

      // Only ch2, then ch0 and ch2 together: ch2 first, ch0 next, ch2 again.
      idleAll();
      setCh(2, 1'b0, 40, 0);
      applyStimulus();
      setCh(0, 1'b0, 41, 0);
      applyStimulus();
      idleAll();
      setCh(2, 1'b0, 42, 0);
      applyStimulus();

      // Boundary: last word and first out-of-range word.
      idleAll();
      setCh(1, 1'b1, DEPTH - 1, 8'hFF);
      applyStimulus();
      idleAll();
      setCh(1, 1'b1, DEPTH, 8'hFF);
      applyStimulus();
      idleAll();
      setCh(3, 1'b0, DEPTH - 1, 0);
      applyStimulus();
      idleAll();
      setCh(3, 1'b0, DEPTH, 0);
      applyStimulus();
      idleAll();
      setCh(2, 1'b0, DEPTH - 256, 0);
      applyStimulus();
      idleAll();
      applyStimulus();
      applyStimulus();

      // Read granted, reset rises next cycle: its pulse must never appear.
      idleAll();
      setCh(3, 1'b0, DEPTH - 1, 0);
      applyStimulus();
      drvRst = 1'b1;
      setCh(1, 1'b0, 5, 0);
      applyStimulus();
      drvRst = 1'b0;
      idleAll();
      applyStimulus();
      applyStimulus();

`ifdef ICE51_MEM_CTRL_PARITY_EN
      // Flip the stored parity bit of word 5, read it, then read a clean word.
      idleAll();
      setCh(0, 1'b1, 5, 8'h3C);
      applyStimulus();
      dut.uMem.mem[5][WIDTH] = ~dut.uMem.mem[5][WIDTH];
      corrupt[5] = 1'b1;
      idleAll();
      setCh(1, 1'b0, 5, 0);
      applyStimulus();
      idleAll();
      setCh(2, 1'b0, 6, 0);
      applyStimulus();
      idleAll();
      applyStimulus();
      applyStimulus();
`endif

      // Random soak: mixed reads/writes, some out of range, rare resets.
      for (int n = 0; n < 500; n++) begin
         idleAll();
         drvRst = ($urandom_range(0, 39) == 0);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 2) != 0) begin
               setCh(ch, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH + 19),
                     $urandom_range(0, 255));
            end
         end
         applyStimulus();
      end
      drvRst = 1'b0;
      idleAll();
      applyStimulus();
      applyStimulus();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
